uart_rx: RTL and testbench
==========================

# uart_rx

Serial UART receiver for the clock board's serial path. It takes the asynchronous `rx` line and oversamples it with the system clock. It detects and validates the start bit, samples `NrOfDataBits` data bits LSB-first at mid-bit, checks the stop bit, and presents the received word with a one-cycle valid strobe or a framing-error strobe. It is the receive-side counterpart of the existing UART transmit chain (start bit, data bits LSB-first, one stop bit, line idles high).

## Interface
- `ClockFrequency`, default 1000000: system clock frequency in Hz.
- `BaudRate`, default 9600: line bit rate in baud.
- `NrOfDataBits`, default 8: data bits per frame, 5..9.
- `reset`  input  1: asynchronous, active-high; returns all state to IDLE.
- `clock`  input  1: single system clock; all logic on rising edge.
- `rx`  input  1: asynchronous serial line; idle high.
- `dataBits`  output  NrOfDataBits: last correctly framed word; held until the next good frame.
- `dataValid`  output  1: one-cycle pulse; `dataBits` updated this cycle.
- `frameError`  output  1: one-cycle pulse; stop bit sampled low.
- `busy`  output  1: high in any state other than IDLE.

## Operation
- Constants:
  - CyclesPerBit = ClockFrequency / BaudRate, integer division. It must be ≥ 8; elaboration fails otherwise.
  - HalfBit = CyclesPerBit / 2.
- `rx` passes through a 2-flop synchronizer, reset value 1. All decisions use the synchronized signal `rxs`.
- IDLE: when `rxs` == 0, go to START and clear the cycle counter.
- START: count to HalfBit-1, then sample `rxs`.
  - If 0, go to DATA with the counter cleared and the bit index at 0.
  - If 1, treat it as a glitch: return to IDLE with no output.
- DATA: every CyclesPerBit cycles, sample `rxs` into the shift register at position `bitIndex` (LSB first).
  - After bit NrOfDataBits-1, go to STOP.
- STOP: after CyclesPerBit cycles, sample `rxs`.
  - If 1: load `dataBits` from the shift register, pulse `dataValid`, go to IDLE.
  - If 0: pulse `frameError`, leave `dataBits` unchanged, go to BREAK.
- BREAK: wait for `rxs` == 1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Counter width is clog2(CyclesPerBit). Bit index width is clog2(NrOfDataBits+1). Neither wraps within a frame.

## Timing
- Reset values:
  - `dataBits` = 0, `dataValid` = 0, `frameError` = 0, `busy` = 0.
  - State IDLE, synchronizer flops = 1.
- Reset asserted mid-frame aborts immediately. No strobe is issued, and the partial word is discarded.
- Synchronizer latency: 2 cycles from an `rx` edge to `rxs`.
- Let T0 be the cycle in which START is entered.
  - Start sample at T0+HalfBit-1.
  - Data bit i sampled at T0+HalfBit-1+(i+1)·CyclesPerBit.
  - Stop sample at T0+HalfBit-1+(NrOfDataBits+1)·CyclesPerBit.
- `dataValid`/`frameError` are registered. They are high for exactly the one cycle after the stop sample.
- `dataValid` and `frameError` are never high together.
- `busy` is high from T0 through the cycle of the stop sample, and also throughout BREAK.
- Back-to-back frames: IDLE is re-entered on the cycle after the stop sample, so a start bit immediately following the stop bit is detected with no lost frame.
- A falling edge during START, DATA or STOP is ignored as a new-frame trigger. Only IDLE detects a start bit.

## Structure
- Shared package `uart_pkg`:
  - state encoding (IDLE, START, DATA, STOP, BREAK);
  - cycles-per-bit function, also used by the transmit chain;
  - clog2 helper.
- Sub-module `uart_rx_sync`: 2-flop synchronizer with a parameterised reset value (1 here). It is reusable for other asynchronous inputs.
- The FSM, counter, bit index and shift register stay in `uart_rx`.

## Test plan
All scenarios use ClockFrequency=1000000 and BaudRate=100000, giving CyclesPerBit=10 and HalfBit=5.
- Frame 0xA5 with a good stop bit -> `dataBits`=0xA5, one `dataValid` pulse, `frameError`=0, `busy` drops after the stop sample.
- `rx` low for 3 cycles, then high -> no strobes, `busy` returns to 0 within 6 cycles, `dataBits` unchanged.
- Frame 0x3C with stop bit 0, line held low for 40 cycles, then high -> one `frameError` pulse, `dataBits` keeps its previous value, no further strobes until `rx` has returned high.
- Frames 0x00 and 0xFF back to back (start bit directly after the stop bit) -> two `dataValid` pulses, 100 cycles apart, carrying 0x00 then 0xFF.
- `reset` asserted during data bit 4 of frame 0x5A, released, then frame 0x81 -> no strobe for 0x5A, `dataBits`=0x81.
- Loopback with the team's UART transmitter, NrOfDataBits=7, 256 random words -> every word received equal to the one sent, zero frame errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks on the clock board's serial path.
//
// Contents:
//   uart_rx_state_e  - receiver FSM encoding (IDLE, START, DATA, STOP, BREAK)
//   cycles_per_bit() - system clocks per serial bit; the transmit chain uses
//                      the same function, so both ends derive an identical
//                      bit period from the same parameters
//   clog2_int()      - ceil(log2(value)), never less than 1, for sizing
//                      counters without ending up with zero-width vectors
//   MinCyclesPerBit  - smallest oversampling ratio the receiver accepts
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } uart_rx_state_e;

  // Below 8 clocks per bit the mid-bit sample point is too close to the
  // bit edges to absorb the synchronizer delay plus baud-rate mismatch.
  localparam int MinCyclesPerBit = 8;

  // Integer division: any fractional remainder becomes accumulated phase
  // error across the frame, which the mid-bit sampling absorbs.
  function automatic int cycles_per_bit(input int clock_hz, input int baud);
    return clock_hz / baud;
  endfunction

  function automatic int clog2_int(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous input.
//
// The reset value is a parameter so the same block serves inputs that idle
// high (UART lines) and inputs that idle low. Resetting to the idle level
// keeps the consumer from seeing a false edge when reset is released.
//
// Ports:
//   clock  in  system clock, rising edge
//   reset  in  asynchronous, active-high; both flops load ResetValue
//   d      in  asynchronous input
//   q      out synchronized copy of d, two clocks of latency
module uart_rx_sync #(
  parameter logic ResetValue = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= ResetValue;
      s2_q <= ResetValue;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start bit, NrOfDataBits data bits LSB-first,
// one stop bit, line idles high.
//
// A low level on the synchronized line while idle starts a frame. The start
// bit is re-checked half a bit later so short glitches are dropped. From
// that point every sample is taken one full bit period apart, which lands
// each sample near the middle of its bit. A good stop bit publishes the word;
// a low stop bit raises a framing error and parks the receiver in BREAK
// until the line goes high again, so a line stuck low yields one error
// rather than a stream of zero-valued frames.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active-high; aborts any frame in flight
//   rx          in   asynchronous serial line, idle high
//   dataBits    out  last correctly framed word, held until the next one
//   dataValid   out  one-cycle pulse, dataBits updated this cycle
//   frameError  out  one-cycle pulse, stop bit was sampled low
//   busy        out  high whenever the FSM is not in IDLE
//
// The FSM state is held in state_q (type uart_rx_state_e) so that checkers
// and waveform viewers can reference it by name.
//
// Handshake: dataValid and frameError are single-cycle strobes with no ready
// input; a consumer must capture dataBits on the cycle dataValid is high or
// at any later time before the next dataValid. The two strobes are mutually
// exclusive.
module uart_rx
  import uart_pkg::*;
#(
  parameter int ClockFrequency = 1000000,
  parameter int BaudRate       = 9600,
  parameter int NrOfDataBits   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rx,
  output logic [NrOfDataBits-1:0] dataBits,
  output logic                    dataValid,
  output logic                    frameError,
  output logic                    busy
);

  localparam int CyclesPerBit = cycles_per_bit(ClockFrequency, BaudRate);
  localparam int HalfBit      = CyclesPerBit / 2;
  localparam int CntW         = clog2_int(CyclesPerBit);
  localparam int IdxW         = clog2_int(NrOfDataBits + 1);

  localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CyclesPerBit - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NrOfDataBits - 1);

  if (CyclesPerBit < MinCyclesPerBit) begin : g_bad_rate
    $error("uart_rx: ClockFrequency/BaudRate must be at least 8");
  end

  if ((NrOfDataBits < 5) || (NrOfDataBits > 9)) begin : g_bad_width
    $error("uart_rx: NrOfDataBits must be in 5..9");
  end

  // --------------------------------------------------------------------
  // Input synchronizer; resets to the idle (high) level.
  // --------------------------------------------------------------------
  logic rxs;

  uart_rx_sync #(
    .ResetValue(1'b1)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rxs)
  );

  // --------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------
  uart_rx_state_e          state_d,  state_q;
  logic [CntW-1:0]         cnt_d,    cnt_q;
  logic [IdxW-1:0]         idx_d,    idx_q;
  logic [NrOfDataBits-1:0] shift_d,  shift_q;
  logic [NrOfDataBits-1:0] data_d,   data_q;
  logic                    valid_d,  valid_q;
  logic                    ferr_d,   ferr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        // Only this state treats a low line as the start of a frame.
        if (!rxs) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end

      RX_START: begin
        if (cnt_q == HalfLast) begin
          if (!rxs) begin
            state_d = RX_DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            // Line went back high before mid start bit: a glitch.
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RX_DATA: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          for (int i = 0; i < NrOfDataBits; i++) begin
            if (idx_q == IdxW'(i)) begin
              shift_d[i] = rxs;
            end
          end
          if (idx_q == IdxLast) begin
            state_d = RX_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RX_STOP: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rxs) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            // Returning to IDLE right away lets a start bit that follows
            // the stop bit without a gap be caught.
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RX_BREAK: begin
        if (rxs) begin
          state_d = RX_IDLE;
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign dataBits   = data_q;
  assign dataValid  = valid_q;
  assign frameError = ferr_q;
  assign busy       = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx. Two instances share clock and reset: an 8-bit receiver
// for the directed and random frame tests and a 7-bit receiver fed by a
// transmitter model for the loopback run. A scoreboard per instance holds
// the expected strobe (kind, word, cycle) for every frame sent; the cycle is
// computed from the frame's start edge with the bit-timing formula.
module tb_uart_rx;

  localparam int ClkHz = 1000000;
  localparam int Baud  = 100000;
  localparam int Cpb   = ClkHz / Baud;
  localparam int Hb    = Cpb / 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rx8   = 1'b1;
  logic rx7   = 1'b1;

  logic [7:0] data8;
  logic       valid8, ferr8, busy8;
  logic [6:0] data7;
  logic       valid7, ferr7, busy7;

  uart_rx #(.ClockFrequency(ClkHz), .BaudRate(Baud), .NrOfDataBits(8)) dut8 (
    .clock(clock), .reset(reset), .rx(rx8),
    .dataBits(data8), .dataValid(valid8), .frameError(ferr8), .busy(busy8)
  );

  uart_rx #(.ClockFrequency(ClkHz), .BaudRate(Baud), .NrOfDataBits(7)) dut7 (
    .clock(clock), .reset(reset), .rx(rx7),
    .dataBits(data7), .dataValid(valid7), .frameError(ferr7), .busy(busy7)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, wanted finish");
    $fatal(1, "watchdog");
  end

  // ---------------- check helpers ----------------
  int total = 0;
  int bad   = 0;

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic void fail_event(input string name);
    total++;
    bad++;
    $display("FAIL %s: got strobe, wanted none (cycle %0d)", name, cyc);
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic       is_err;
    logic [8:0] data;
    int         cyc;
  } exp_t;

  exp_t exp8_q[$];
  exp_t exp7_q[$];
  exp_t e8, e7;
  logic [8:0] last8 = '0;
  logic [8:0] last7 = '0;
  int rcv7 = 0;
  int ferr7_cnt = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (valid8 && ferr8) fail_event("strobe8_both");
      if (valid8 || ferr8) begin
        if (exp8_q.size() == 0) begin
          fail_event("strobe8_unexpected");
        end else begin
          e8 = exp8_q.pop_front();
          check("strobe8_kind", 32'(ferr8), 32'(e8.is_err));
          check("strobe8_cycle", cyc, e8.cyc);
          if (!e8.is_err) last8 = e8.data;
          check("strobe8_data", 32'(data8), 32'(last8));
        end
      end else if (exp8_q.size() != 0 && cyc > exp8_q[0].cyc) begin
        e8 = exp8_q.pop_front();
        check("strobe8_missed", 32'(cyc), e8.cyc);
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (valid7 && ferr7) fail_event("strobe7_both");
      if (ferr7) ferr7_cnt++;
      if (valid7) rcv7++;
      if (valid7 || ferr7) begin
        if (exp7_q.size() == 0) begin
          fail_event("strobe7_unexpected");
        end else begin
          e7 = exp7_q.pop_front();
          check("strobe7_kind", 32'(ferr7), 32'(e7.is_err));
          check("strobe7_cycle", cyc, e7.cyc);
          if (!e7.is_err) last7 = e7.data;
          check("strobe7_data", 32'(data7), 32'(last7));
        end
      end else if (exp7_q.size() != 0 && cyc > exp7_q[0].cyc) begin
        e7 = exp7_q.pop_front();
        check("strobe7_missed", 32'(cyc), e7.cyc);
      end
    end
  end

  // ---------------- driver tasks (all start and end on a negedge) ----------
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic drive_bit(input int lane, input logic v);
    if (lane == 0) rx8 = v;
    else           rx7 = v;
    repeat (Cpb) @(negedge clock);
  endtask

  // Transmitter model: start, n data bits LSB-first, stop. The strobe is
  // expected on the cycle after the stop sample, which is taken
  // Hb-1+(n+1)*Cpb cycles after the receiver enters START; START is entered
  // two synchronizer cycles after the edge that first sees rx low.
  task automatic send_frame(input int lane, input logic [8:0] word,
                            input logic stop_bit, input logic exp_err);
    int   n;
    exp_t e;
    n = (lane == 0) ? 8 : 7;
    e.is_err = exp_err;
    e.data   = word;
    e.cyc    = (cyc + 1) + 2 + Hb + (n + 1) * Cpb;
    if (lane == 0) exp8_q.push_back(e);
    else           exp7_q.push_back(e);
    drive_bit(lane, 1'b0);
    for (int i = 0; i < n; i++) drive_bit(lane, word[i]);
    drive_bit(lane, stop_bit);
  endtask

  task automatic watch_busy(input int k, input logic exp_err);
    wait_cyc(k + 2);
    check("busy_at_t0", 32'(busy8), 32'd1);
    wait_cyc(k + 1 + Hb + 9 * Cpb);
    check("busy_stop_sample", 32'(busy8), 32'd1);
    wait_cyc(k + 2 + Hb + 9 * Cpb);
    check("busy_after_stop", 32'(busy8), 32'(exp_err));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold_low;
    int         gap;
    logic       exp_ferr;
    logic [7:0] exp_bits;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int         k;
    int         n;
    logic [7:0] w;
    logic       stop;

    tbl[0] = '{8'hA5, 1'b1,  0, 20, 1'b0, 8'hA5};
    tbl[1] = '{8'h3C, 1'b0, 40, 20, 1'b1, 8'hA5};
    tbl[2] = '{8'h00, 1'b1,  0,  0, 1'b0, 8'h00};
    tbl[3] = '{8'hFF, 1'b1,  0, 20, 1'b0, 8'hFF};
    tbl[4] = '{8'h01, 1'b0,  0,  4, 1'b1, 8'hFF};
    tbl[5] = '{8'h80, 1'b1,  0, 10, 1'b0, 8'h80};

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_busy8",  32'(busy8),  32'd0);
    check("rst_valid8", 32'(valid8), 32'd0);
    check("rst_ferr8",  32'(ferr8),  32'd0);
    check("rst_data8",  32'(data8),  32'd0);
    check("rst_busy7",  32'(busy7),  32'd0);
    check("rst_data7",  32'(data7),  32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("idle_busy8", 32'(busy8), 32'd0);

    // Table-driven frames on the 8-bit receiver
    for (int i = 0; i < 6; i++) begin
      k = cyc + 1;
      fork
        send_frame(0, {1'b0, tbl[i].data}, tbl[i].stop, tbl[i].exp_ferr);
        watch_busy(k, tbl[i].exp_ferr);
      join
      check("tbl_data", 32'(data8), 32'(tbl[i].exp_bits));
      if (tbl[i].exp_ferr) begin
        repeat (tbl[i].hold_low) @(negedge clock);
        check("break_busy", 32'(busy8), 32'd1);
        rx8 = 1'b1;
      end
      repeat (tbl[i].gap) @(negedge clock);
    end

    // Start-bit glitch: 3 cycles low
    rx8 = 1'b0;
    repeat (3) @(negedge clock);
    rx8 = 1'b1;
    check("glitch_busy_high", 32'(busy8), 32'd1);
    n = 0;
    while (busy8 === 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("glitch_busy_drop", 32'(n >= 1 && n <= 6), 32'd1);
    check("glitch_data", 32'(data8), 32'(last8));
    repeat (10) @(negedge clock);

    // Reset during data bit 4 of 0x5A, then 0x81
    w = 8'h5A;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, w[i]);
    rx8 = w[4];
    repeat (4) @(negedge clock);
    reset = 1'b1;
    rx8   = 1'b1;
    last8 = '0;
    last7 = '0;
    @(negedge clock);
    check("midrst_busy",  32'(busy8),  32'd0);
    check("midrst_valid", 32'(valid8), 32'd0);
    check("midrst_data",  32'(data8),  32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    send_frame(0, 9'h081, 1'b1, 1'b0);
    check("after_rst_data", 32'(data8), 32'h81);
    repeat (5) @(negedge clock);

    // Random frames on the 8-bit receiver, occasional bad stop bits
    for (int i = 0; i < 40; i++) begin
      w    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      send_frame(0, {1'b0, w}, stop, !stop);
      if (!stop) begin
        repeat ($urandom_range(0, 30)) @(negedge clock);
        rx8 = 1'b1;
        repeat ($urandom_range(2, 12)) @(negedge clock);
      end else begin
        repeat ($urandom_range(0, 12)) @(negedge clock);
      end
    end

    // Loopback on the 7-bit receiver
    for (int i = 0; i < 256; i++) begin
      send_frame(1, 9'($urandom_range(0, 127)), 1'b1, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    repeat (150) @(negedge clock);
    check("loop_count", rcv7, 32'd256);
    check("loop_ferr",  ferr7_cnt, 32'd0);
    check("q8_drained", exp8_q.size(), 32'd0);
    check("q7_drained", exp7_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
